// File: rtl/crc_pkg.sv
// Shared CRC-32 (reflected, IEEE 802.3) constants, the feeder state encoding,
// and a byte-fold helper used by the CRC engine.
package crc_pkg;

  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    TAIL,
    CAPTURE
  } feeder_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_core.sv
// Byte-serial CRC-32 engine: folds crc_in while en&&we; on the first edge with
// en low after en high it publishes the final CRC and reinitializes.
module crc_core
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [7:0]  crc_in,
  output logic [31:0] crc_out
);

  logic [31:0] reg_q, reg_d;
  logic [31:0] out_q, out_d;
  logic        en_q;

  always_comb begin
    reg_d = reg_q;
    out_d = out_q;
    if (en && we) begin
      reg_d = crc32_byte(reg_q, crc_in);
    end else if (!en && en_q) begin
      out_d = reg_q ^ CRC32_XOROUT;
      reg_d = CRC32_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= CRC32_INIT;
      out_q <= '0;
      en_q  <= 1'b0;
    end else begin
      reg_q <= reg_d;
      out_q <= out_d;
      en_q  <= en;
    end
  end

  assign crc_out = out_q;

endmodule

// File: rtl/rom_crc_feeder.sv
// Download-stream front end for crc_core: frames the engine enable window,
// feeds one byte per strobe and captures/compares the finished CRC.
module rom_crc_feeder
  import crc_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dl_active,
  input  logic             dl_wr,
  input  logic [7:0]       dl_data,
  input  logic [31:0]      exp_crc,
  output logic             crc_en,
  output logic             crc_we,
  output logic [7:0]       crc_byte,
  input  logic [31:0]      crc_value,
  output logic             busy,
  output logic             done,
  output logic [31:0]      crc_result,
  output logic [CNT_W-1:0] byte_count,
  output logic             match,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  feeder_state_t    state_q, state_d;
  logic             act_q, act_d;
  logic             start_pend_q, start_pend_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic             we_q, we_d;
  logic [7:0]       byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      res_q, res_d;
  logic             match_q, match_d;

  logic rise, sat, accept, drop, start, hit;

  always_comb begin
    state_d      = state_q;
    act_d        = dl_active;
    start_pend_d = start_pend_q;
    pend_ovf_d   = pend_ovf_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    res_d        = res_q;
    match_d      = match_q;
    start        = 1'b0;

    rise   = dl_active && !act_q;
    sat    = (cnt_q == CNT_MAX);
    accept = dl_wr && (state_q == RUN) && !sat;
    drop   = dl_wr && !accept;
    hit    = (crc_value == exp_crc);
    we_d   = accept;
    byte_d = dl_wr ? dl_data : byte_q;

    if (accept) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (rise)      start = 1'b1;
        else if (drop) ovf_d = 1'b1;
      end
      RUN: begin
        if (drop) ovf_d = 1'b1;
        if (!dl_active) state_d = FLUSH;
      end
      FLUSH, TAIL: begin
        state_d = (state_q == FLUSH) ? TAIL : CAPTURE;
        if (rise) start_pend_d = 1'b1;
        // Drops after a re-rise belong to the pending run, not the finishing one.
        if (drop) begin
          if (start_pend_q || rise) pend_ovf_d = 1'b1;
          else                      ovf_d      = 1'b1;
        end
      end
      CAPTURE: begin
        res_d   = crc_value;
        match_d = hit;
        if (start_pend_q || rise) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          if (drop) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d      = RUN;
      cnt_d        = '0;
      ovf_d        = pend_ovf_q || drop;
      pend_ovf_d   = 1'b0;
      start_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_q        <= 1'b0;
      start_pend_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      res_q        <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      start_pend_q <= start_pend_d;
      pend_ovf_q   <= pend_ovf_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      res_q        <= res_d;
      match_q      <= match_d;
    end
  end

  // Result is bypassed during CAPTURE so it is already valid alongside done.
  assign done       = (state_q == CAPTURE);
  assign crc_result = done ? crc_value : res_q;
  assign match      = done ? hit : match_q;
  assign crc_en     = (state_q == RUN) || (state_q == FLUSH);
  assign crc_we     = we_q;
  assign crc_byte   = byte_q;
  assign busy       = (state_q != IDLE);
  assign byte_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_crc_feeder.sv
// Scoreboard bench for rom_crc_feeder + crc_core: a default-width instance and a
// CNT_W=4 instance for counter saturation.
module tb_rom_crc_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_act, a_wr, a_en, a_we, a_busy, a_done, a_match, a_ovf;
  logic [7:0]  a_data, a_byte;
  logic [31:0] a_exp, a_val, a_res;
  logic [23:0] a_cnt;

  logic        b_act, b_wr, b_en, b_we, b_busy, b_done, b_match, b_ovf;
  logic [7:0]  b_data, b_byte;
  logic [31:0] b_exp, b_val, b_res;
  logic [3:0]  b_cnt;

  rom_crc_feeder #(.CNT_W(24)) u_a (
    .clk(clk), .rst_n(rst_n), .dl_active(a_act), .dl_wr(a_wr), .dl_data(a_data),
    .exp_crc(a_exp), .crc_en(a_en), .crc_we(a_we), .crc_byte(a_byte),
    .crc_value(a_val), .busy(a_busy), .done(a_done), .crc_result(a_res),
    .byte_count(a_cnt), .match(a_match), .overflow(a_ovf)
  );
  crc_core u_ca (.clk(clk), .rst_n(rst_n), .en(a_en), .we(a_we), .crc_in(a_byte), .crc_out(a_val));

  rom_crc_feeder #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .dl_active(b_act), .dl_wr(b_wr), .dl_data(b_data),
    .exp_crc(b_exp), .crc_en(b_en), .crc_we(b_we), .crc_byte(b_byte),
    .crc_value(b_val), .busy(b_busy), .done(b_done), .crc_result(b_res),
    .byte_count(b_cnt), .match(b_match), .overflow(b_ovf)
  );
  crc_core u_cb (.clk(clk), .rst_n(rst_n), .en(b_en), .we(b_we), .crc_in(b_byte), .crc_out(b_val));

  typedef struct {
    logic [31:0] crc;
    logic [23:0] cnt;
    logic        m;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  byte         vec[0:31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_done) begin
      if (q_a.size() == 0) chk("a_unexpected_done", {31'b0, a_done}, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_crc_result", a_res, e.crc);
        chk("a_byte_count", {8'b0, a_cnt}, {8'b0, e.cnt});
        chk("a_match", {31'b0, a_match}, {31'b0, e.m});
        chk("a_overflow", {31'b0, a_ovf}, {31'b0, e.ovf});
        chk("a_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_done) begin
      if (q_b.size() == 0) chk("b_unexpected_done", {31'b0, b_done}, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_crc_result", b_res, e.crc);
        chk("b_byte_count", {28'b0, b_cnt}, {8'b0, e.cnt});
        chk("b_match", {31'b0, b_match}, {31'b0, e.m});
        chk("b_overflow", {31'b0, b_ovf}, {31'b0, e.ovf});
        chk("b_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Independent reference: MSB-first CRC on bit-reversed bytes, poly 04C11DB7.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c, r;
    logic [7:0]  rb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) rb[k] = vec[i][7-k];
      c = c ^ {rb, 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic act, input logic wr, input logic [7:0] d);
    if (sel) begin b_act = act; b_wr = wr; b_data = d; end
    else     begin a_act = act; a_wr = wr; a_data = d; end
  endtask

  task automatic push(input bit sel, input logic [31:0] crc, input logic [23:0] cnt,
                      input logic m, input logic ovf);
    exp_t e;
    e.crc = crc; e.cnt = cnt; e.m = m; e.ovf = ovf; e.cyc = cyc + 3;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      step();
    end
    chk("result_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) vec[i] = s[i];
  endtask

  task automatic run(input bit sel, input int n, input int gap, input logic [31:0] expc,
                     input logic [31:0] crc, input logic [23:0] cnt, input logic m,
                     input logic ovf);
    if (sel) b_exp = expc;
    else     a_exp = expc;
    drive(sel, 1'b1, 1'b0, 8'h00);
    step();
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b1, 1'b1, vec[i]);
      step();
      drive(sel, 1'b1, 1'b0, 8'h00);
      repeat (gap) step();
    end
    drive(sel, 1'b0, 1'b0, 8'h00);
    push(sel, crc, cnt, m, ovf);
    step();
    drain();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"},   {31'b0, a_busy},  32'd0);
    chk({tag, "_done"},   {31'b0, a_done},  32'd0);
    chk({tag, "_result"}, a_res,            32'd0);
    chk({tag, "_count"},  {8'b0, a_cnt},    32'd0);
    chk({tag, "_match"},  {31'b0, a_match}, 32'd0);
    chk({tag, "_ovf"},    {31'b0, a_ovf},   32'd0);
    chk({tag, "_en"},     {31'b0, a_en},    32'd0);
    chk({tag, "_we"},     {31'b0, a_we},    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] crc15;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    a_exp = '0;
    b_exp = '0;
    repeat (3) step();
    check_cleared("reset");
    chk("reset_b_busy", {31'b0, b_busy}, 32'd0);
    rst_n = 1'b1;
    step();

    load_str("123456789");
    run(1'b0, 9, 0, 32'hCBF4_3926, 32'hCBF4_3926, 24'd9, 1'b1, 1'b0);

    vec[0] = 8'h00;
    run(1'b0, 1, 4, 32'hD202_EF8D, 32'hD202_EF8D, 24'd1, 1'b1, 1'b0);
    load_str("a");
    run(1'b0, 1, 0, 32'hE8B7_BE43, 32'hE8B7_BE43, 24'd1, 1'b1, 1'b0);
    run(1'b0, 1, 0, 32'hE8B7_BE42, 32'hE8B7_BE43, 24'd1, 1'b0, 1'b0);

    run(1'b0, 0, 0, 32'h0000_0000, 32'h0000_0000, 24'd0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) vec[i] = 8'(i * 37 + 5);
    crc15 = ref_crc(15);
    run(1'b1, 20, 0, crc15, crc15, 24'd15, 1'b1, 1'b1);

    load_str("123456789");
    a_exp = 32'hCBF4_3926;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, vec[i]);
      step();
    end
    chk("midrun_busy", {31'b0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check_cleared("async_reset");
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run(1'b0, 9, 0, 32'hCBF4_3926, 32'hCBF4_3926, 24'd9, 1'b1, 1'b0);

    a_exp = 32'hCBF4_3926;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b1, vec[i]);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    push(1'b0, 32'hCBF4_3926, 24'd9, 1'b1, 1'b0);
    step();
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h55);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("pending_restart_busy", {31'b0, a_busy}, 32'd1);
    a_exp = 32'hE8B7_BE43;
    drive(1'b0, 1'b1, 1'b1, 8'h61);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    push(1'b0, 32'hE8B7_BE43, 24'd1, 1'b1, 1'b1);
    step();
    drain();

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
